gate_result_collector: RTL and testbench

//  Downstream of the 2-port recurrent linear stage: captures its paired even/odd results.
//  On each in_valid, writes din_even/din_odd into vector slots base+2k and base+2k+1.

---
 rtl/gate_result_collector.sv | 111 +++++++++++
 tb/tb_gate_result_collector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_collector.sv
// Collects paired even/odd results from the recurrent linear stage into a slot vector.
// The assembled gate vector (z | r | h) is handed to the GRU elementwise stage over valid/ready.
module gate_result_collector #(
  parameter int DW      = 32,
  parameter int VEC_LEN = 96,
  parameter int IDX_W   = 7,
  parameter int CNT_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [IDX_W-1:0]      cfg_base,
  input  logic [CNT_W-1:0]      cfg_pairs,
  input  logic                  in_valid,
  input  logic [DW-1:0]         din_even,
  input  logic [DW-1:0]         din_odd,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW*VEC_LEN-1:0] vec_out,
  output logic                  err
);

  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  state_e           state_q;
  logic [DW-1:0]    slot_q [VEC_LEN];
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] remaining_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             err_q;

  // End index is formed one bit wider so base + 2*pairs cannot wrap past VEC_LEN.
  logic [SUM_W-1:0] cfg_end;
  logic             start_legal;

  assign cfg_end     = SUM_W'(cfg_base) + SUM_W'({cfg_pairs, 1'b0});
  assign start_legal = !cfg_base[0] && (cfg_pairs != '0) && (cfg_end <= SUM_W'(VEC_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: the slot array is reset here on purpose: collected results must read as zero
      // after rst, so it cannot be left as plain unreset RAM.
      for (int i = 0; i < VEC_LEN; i++) slot_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            for (int i = 0; i < VEC_LEN; i++) slot_q[i] <= '0;
          end
          if (start) begin
            if (start_legal) begin
              state_q     <= COLLECT;
              ptr_q       <= cfg_base;
              remaining_q <= cfg_pairs;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          // A pair arriving with no pass open has nowhere to go.
          if (in_valid) err_q <= 1'b1;
        end

        COLLECT: begin
          if (start) err_q <= 1'b1;
          if (in_valid) begin
            slot_q[ptr_q]        <= din_even;
            slot_q[ptr_q + 1'b1] <= din_odd;
            ptr_q                <= ptr_q + 2'd2;
            remaining_q          <= remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (start || in_valid) err_q <= 1'b1;
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < VEC_LEN; g++) begin : g_pack
    assign vec_out[g*DW +: DW] = slot_q[g];
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gate_result_collector.sv
// Directed bench for gate_result_collector: a pass-level model tracks expected slots and flags,
// a negedge compare process checks every cycle, and literal spot checks pin the model.
module tb_gate_result_collector;

  localparam int DW      = 32;
  localparam int VEC_LEN = 96;
  localparam int IDX_W   = 7;
  localparam int CNT_W   = 6;

  logic                  clk = 1'b0;
  logic                  rst, clr, start, in_valid, out_ready;
  logic [IDX_W-1:0]      cfg_base;
  logic [CNT_W-1:0]      cfg_pairs;
  logic [DW-1:0]         din_even, din_odd;
  logic                  busy, out_valid, err;
  logic [DW*VEC_LEN-1:0] vec_out;

  gate_result_collector #(.DW(DW), .VEC_LEN(VEC_LEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .cfg_base(cfg_base), .cfg_pairs(cfg_pairs),
    .in_valid(in_valid), .din_even(din_even), .din_odd(din_odd), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .vec_out(vec_out), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Pass-level model: an open pass has a next slot and a count of pairs still owed.
  logic [DW-1:0] m_slot [VEC_LEN];
  bit            m_open, m_ready_out, m_err;
  int            m_next, m_owed;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dut_slot(input int i);
    return vec_out[i*DW +: DW];
  endfunction

  // Expected effect of one clock edge, stated in pass terms.
  task automatic model_edge();
    if (rst) begin
      m_open = 0; m_ready_out = 0; m_err = 0; m_next = 0; m_owed = 0;
      for (int i = 0; i < VEC_LEN; i++) m_slot[i] = '0;
    end else if (!m_open) begin
      if (clr) for (int i = 0; i < VEC_LEN; i++) m_slot[i] = '0;
      if (start) begin
        if (cfg_base % 2 == 0 && cfg_pairs != 0 && int'(cfg_base) + 2 * int'(cfg_pairs) <= VEC_LEN) begin
          m_open = 1; m_next = int'(cfg_base); m_owed = int'(cfg_pairs);
        end else m_err = 1;
      end
      if (in_valid) m_err = 1;
    end else if (!m_ready_out) begin
      if (start) m_err = 1;
      if (in_valid) begin
        m_slot[m_next] = din_even;
        m_slot[m_next + 1] = din_odd;
        m_next += 2;
        m_owed--;
        if (m_owed == 0) m_ready_out = 1;
      end
    end else begin
      if (start || in_valid) m_err = 1;
      if (out_ready) begin m_open = 0; m_ready_out = 0; end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      bad = -1;
      check("busy", {31'b0, busy}, {31'b0, m_open});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_ready_out});
      check("err", {31'b0, err}, {31'b0, m_err});
      for (int i = 0; i < VEC_LEN; i++)
        if (bad < 0 && dut_slot(i) !== m_slot[i]) bad = i;
      if (bad < 0) check("vec_out", '0, '0 + (vec_out !== vec_out));
      else check($sformatf("vec_out[%0d]", bad), dut_slot(bad), m_slot[bad]);
    end
  end

  task automatic idle_inputs();
    rst = 0; clr = 0; start = 0; in_valid = 0; out_ready = 0;
    cfg_base = '0; cfg_pairs = '0; din_even = '0; din_odd = '0;
  endtask

  // Apply the currently driven inputs across one rising edge, then return to idle inputs.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    idle_inputs();
  endtask

  task automatic do_start(input int base, input int pairs, input bit with_clr);
    start = 1; cfg_base = IDX_W'(base); cfg_pairs = CNT_W'(pairs); clr = with_clr;
    tick();
  endtask

  task automatic do_pair(input logic [DW-1:0] e, input logic [DW-1:0] o);
    in_valid = 1; din_even = e; din_odd = o;
    tick();
  endtask

  task automatic accept();
    out_ready = 1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, wanted $finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < VEC_LEN; i++) m_slot[i] = '0;

    // T1 reset
    rst = 1; tick();
    rst = 1; tick();
    chk_en = 1;
    check("t1_out_valid", {31'b0, out_valid}, 32'd0);
    check("t1_slot0", dut_slot(0), 32'd0);

    // T2 z pass, back-to-back pairs
    do_start(0, 16, 0);
    check("t2_busy", {31'b0, busy}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      check("t2_no_early_valid", {31'b0, out_valid}, 32'd0);
      do_pair(DW'(2 * k), DW'(2 * k + 1));
    end
    check("t2_valid_after_last", {31'b0, out_valid}, 32'd1);
    check("t2_slot31", dut_slot(31), 32'd31);
    check("t2_slot32", dut_slot(32), 32'd0);
    tick();
    accept();
    check("t2_idle_after_accept", {31'b0, busy}, 32'd0);

    // T3 + T4 r/h pass with gaps, delayed accept, accumulating onto the z segment
    do_start(32, 32, 0);
    for (int k = 0; k < 32; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      do_pair(32'hA000_0000 + DW'(32 + 2 * k), 32'hA000_0000 + DW'(33 + 2 * k));
    end
    out_ready = 0;
    repeat (5) tick();
    check("t3_hold_valid", {31'b0, out_valid}, 32'd1);
    check("t4_slot5", dut_slot(5), 32'd5);
    check("t4_slot95", dut_slot(95), 32'hA000_005F);
    accept();
    check("t3_released", {31'b0, out_valid}, 32'd0);

    // T5 illegal configurations; slots must not move
    do_start(33, 1, 0);
    check("t5_odd_base_err", {31'b0, err}, 32'd1);
    do_start(64, 17, 0);
    do_start(64, 0, 0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_slot64", dut_slot(64), 32'hA000_0040);

    // Boundary: clr with a legal start ending exactly at VEC_LEN; clr while busy ignored
    do_start(94, 1, 1);
    check("clr_slot0", dut_slot(0), 32'd0);
    clr = 1; tick();
    do_pair(32'h1234_5678, 32'h9ABC_DEF0);
    check("edge_slot95", dut_slot(95), 32'h9ABC_DEF0);
    accept();
    // start with in_valid in IDLE: start taken, pair dropped
    start = 1; cfg_base = 7'd10; cfg_pairs = 6'd1; in_valid = 1; din_even = 32'hDEAD; din_odd = 32'hBEEF;
    tick();
    check("drop_slot10", dut_slot(10), 32'd0);
    do_pair(32'h55, 32'h66);
    accept();
    check("pass_slot11", dut_slot(11), 32'h66);

    // T6 abuse
    rst = 1; tick();
    check("t6_err_cleared", {31'b0, err}, 32'd0);
    do_start(0, 4, 0);
    do_start(40, 2, 0);
    check("t6_start_busy_err", {31'b0, err}, 32'd1);
    for (int k = 0; k < 4; k++) do_pair(DW'(100 + k), DW'(200 + k));
    do_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("t6_hold_frozen", dut_slot(6), 32'd103);
    accept();
    do_start(0, 8, 0);
    for (int k = 0; k < 5; k++) do_pair(DW'(7 + k), DW'(9 + k));
    rst = 1; tick();
    check("t6_rst_slot2", dut_slot(2), 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    tick();

    chk_en = 0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
